pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequencing controller for the 5-stage pipeline (IF/ID/EXE/MEM/WB).
//  - Selects operand forwarding into ID.
//  - Detects load-use hazards and inserts a one-cycle bubble.
//  - Kills wrong-path fetches after a taken branch/jump.
//  - Freezes the whole pipeline while data memory is not ready.
//  - Keeps stall/flush performance counters.
//  - Sits beside the ID stage and drives the PC, IR and stage-register enables.
// PARAMETERS
//  BR_PENALTY   1     cycles of IF kill after a taken branch/jump in ID (1..7)
//  MEM_TIMEOUT  15    max MEMWAIT cycles before forced release (1..255)
//  CNT_W        16    width of the saturating performance counters
// PORTS
//  clk           in   1      clock; all state updates on rising edge
//  clrn          in   1      synchronous active-low reset
//  id_rs         in   5      rs field of the instruction in ID
//  id_rt         in   5      rt field of the instruction in ID
//  id_use_rs     in   1      ID instruction reads rs
//  id_use_rt     in   1      ID instruction reads rt
//  id_pcsource   in   2      ID next-PC select (00 = sequential; else taken)
//  exe_wreg      in   1      EXE will write the register file
//  exe_m2reg     in   1      EXE instruction is a load
//  exe_rn        in   5      EXE destination register
//  mem_wreg      in   1      MEM will write the register file
//  mem_m2reg     in   1      MEM instruction is a load
//  mem_wmem      in   1      MEM instruction is a store
//  mem_rn        in   5      MEM destination register
//  mem_ready     in   1      data memory access completes this cycle
//  fwda          out  2      rs source: 00 regfile, 01 EXE alu, 10 MEM alu, 11 MEM mo
//  fwdb          out  2      rt source; same encoding as fwda
//  wpc           out  1      PC write enable
//  wir           out  1      IR (IF/ID) write enable
//  bubble_ex     out  1      load zeroed controls into ID/EXE
//  freeze        out  1      hold ID/EXE, EXE/MEM and MEM/WB
//  flush_if      out  1      load NOP into IR
//  mem_timeout   out  1      one-cycle pulse on forced MEMWAIT release
//  state         out  2      00 RUN, 01 FLUSH, 10 MEMWAIT
//  stall_cnt     out  CNT_W  saturating count of cycles with wpc=0
//  flush_cnt     out  CNT_W  saturating count of flush_if cycles
// BEHAVIOUR
//  Reset, and while clrn=0:
//   - state=RUN; counters=0; mem_timeout=0.
//   - Comb outputs forced to wpc=1, wir=1, bubble_ex=0, freeze=0, flush_if=0, fwda=fwdb=00.
//  Forwarding (comb; fwda shown, fwdb the same with rt/use_rt):
//   - 01 if exe_wreg & ~exe_m2reg & exe_rn!=0 & exe_rn==id_rs.
//   - else 10/11 if mem_wreg & mem_rn!=0 & mem_rn==id_rs (11 when mem_m2reg).
//   - else 00. Register 0 is never forwarded.
//  Load-use (comb): lu = exe_wreg & exe_m2reg & exe_rn!=0 &
//   ((id_use_rs & id_rs==exe_rn) | (id_use_rt & id_rt==exe_rn)).
//  memhold = (mem_m2reg|mem_wmem) & ~mem_ready.
//  Priority: MEMWAIT/memhold > lu > taken branch.
//  Outputs by state/condition:
//   - memhold or MEMWAIT: wpc=wir=0, freeze=1, bubble_ex=0, flush_if=0.
//   - lu (RUN/FLUSH, no memhold): wpc=wir=0, bubble_ex=1. Branch in ID ignored this
//     cycle; it is re-evaluated next cycle with the forwarded operand.
//   - RUN, taken (id_pcsource!=00), no lu/memhold: wpc=wir=1, flush_if=1.
//   - FLUSH: flush_if=1, wpc=wir=1; id_pcsource ignored.
//  FSM (rising clk, clrn=1):
//   - RUN -> MEMWAIT on memhold; tcnt<=0.
//   - RUN -> FLUSH on taken & ~lu, only if BR_PENALTY>1; fcnt<=1.
//   - FLUSH: fcnt++; -> RUN when fcnt==BR_PENALTY-1; memhold preempts -> MEMWAIT
//     (remaining flush is abandoned).
//   - MEMWAIT: tcnt++; -> RUN when mem_ready=1.
//   - MEMWAIT: when tcnt==MEM_TIMEOUT-1 and still not ready -> RUN, pulse mem_timeout.
//  Counters: +1 per qualifying cycle; saturate at all-ones (no wrap).
//  Reset mid-MEMWAIT/FLUSH: abort to RUN at that edge; no timeout pulse.
// STRUCTURE
//  - Shared package (pipe_pkg): FWD_* codes (2'b00..2'b11), ST_RUN/ST_FLUSH/ST_MEMWAIT,
//    PCSRC_SEQ=2'b00.
//  - Sub-module: fwd_select (comb, one instance each for rs and rt).
//  - FSM, counters and hazard logic live in this module.
// TESTING
//  - exe: wreg=1, m2reg=0, rn=5; id_rs=5 -> fwda=01.
//    Add mem_wreg=1, mem_rn=5: fwda stays 01 (EXE wins).
//    rn=0 anywhere -> 00.
//  - exe load to r3; id_rt=3, use_rt=1 -> one cycle wpc=wir=0, bubble_ex=1.
//    Next cycle (load now in MEM): fwdb=11, no stall.
//  - BR_PENALTY=3; taken in ID -> flush_if high 3 consecutive cycles.
//    state sequence RUN, FLUSH, FLUSH, RUN; flush_cnt=3.
//  - mem_m2reg=1, mem_ready low 4 cycles -> freeze=1, wpc=0 for 4 cycles.
//    stall_cnt=4, no timeout.
//  - MEM_TIMEOUT=15, mem_ready held 0 -> mem_timeout pulses once, on the 15th
//    MEMWAIT cycle; state returns to RUN.
//  - clrn=0 during MEMWAIT -> next edge: state=RUN, counters 0.
//    Counters saturate: CNT_W=4, 20 stalls -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding sources,
// controller states and the sequential next-PC select value.
package pipe_pkg;

   localparam logic [1:0] FWD_RF      = 2'b00;
   localparam logic [1:0] FWD_EXE     = 2'b01;
   localparam logic [1:0] FWD_MEM_ALU = 2'b10;
   localparam logic [1:0] FWD_MEM_MO  = 2'b11;

   localparam logic [1:0] PCSRC_SEQ   = 2'b00;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_FLUSH   = 2'b01,
      ST_MEMWAIT = 2'b10
   } state_t;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one ID source register.
// EXE results win over MEM; loads still in EXE cannot forward, and r0 never does.
module fwd_select
   import pipe_pkg::*;
(
   input  logic [4:0] src,
   input  logic       exe_wreg,
   input  logic       exe_m2reg,
   input  logic [4:0] exe_rn,
   input  logic       mem_wreg,
   input  logic       mem_m2reg,
   input  logic [4:0] mem_rn,
   output logic [1:0] fwd
);

   always_comb begin
      fwd = FWD_RF;
      if (exe_wreg && !exe_m2reg && exe_rn != 5'd0 && exe_rn == src)
         fwd = FWD_EXE;
      else if (mem_wreg && mem_rn != 5'd0 && mem_rn == src)
         fwd = mem_m2reg ? FWD_MEM_MO : FWD_MEM_ALU;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller beside ID: forwarding, load-use bubbles,
// branch kill of wrong-path fetches, memory-wait freeze and stall/flush counters.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int BR_PENALTY  = 1,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [1:0]       id_pcsource,
   input  logic             exe_wreg,
   input  logic             exe_m2reg,
   input  logic [4:0]       exe_rn,
   input  logic             mem_wreg,
   input  logic             mem_m2reg,
   input  logic             mem_wmem,
   input  logic [4:0]       mem_rn,
   input  logic             mem_ready,
   output logic [1:0]       fwda,
   output logic [1:0]       fwdb,
   output logic             wpc,
   output logic             wir,
   output logic             bubble_ex,
   output logic             freeze,
   output logic             flush_if,
   output logic             mem_timeout,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   state_t     state_reg;
   logic [2:0] fcnt_reg;
   logic [7:0] tcnt_reg;
   logic [1:0] fwda_sel, fwdb_sel;
   logic       lu, memhold, hold, taken;

   fwd_select u_fwd_rs (
      .src(id_rs), .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_rn(exe_rn),
      .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn), .fwd(fwda_sel)
   );

   fwd_select u_fwd_rt (
      .src(id_rt), .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_rn(exe_rn),
      .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn), .fwd(fwdb_sel)
   );

   assign lu = exe_wreg && exe_m2reg && exe_rn != 5'd0 &&
               ((id_use_rs && id_rs == exe_rn) || (id_use_rt && id_rt == exe_rn));
   assign memhold = (mem_m2reg || mem_wmem) && !mem_ready;
   // The stalled access stays frozen in MEM until it completes or times out.
   assign hold  = memhold || (state_reg == ST_MEMWAIT && !mem_ready);
   assign taken = id_pcsource != PCSRC_SEQ;
   assign state = state_reg;

   always_comb begin
      wpc       = 1'b1;
      wir       = 1'b1;
      bubble_ex = 1'b0;
      freeze    = 1'b0;
      flush_if  = 1'b0;
      fwda      = FWD_RF;
      fwdb      = FWD_RF;
      if (clrn) begin
         fwda = fwda_sel;
         fwdb = fwdb_sel;
         if (hold) begin
            wpc    = 1'b0;
            wir    = 1'b0;
            freeze = 1'b1;
         end else if (lu) begin
            wpc       = 1'b0;
            wir       = 1'b0;
            bubble_ex = 1'b1;
         end else if (state_reg == ST_FLUSH || taken) begin
            flush_if = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_reg   <= ST_RUN;
         fcnt_reg    <= 3'd0;
         tcnt_reg    <= 8'd0;
         mem_timeout <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         mem_timeout <= 1'b0;
         if (!wpc && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
         if (flush_if && flush_cnt != {CNT_W{1'b1}})
            flush_cnt <= flush_cnt + 1'b1;

         case (state_reg)
            ST_RUN: begin
               if (memhold) begin
                  state_reg <= ST_MEMWAIT;
                  tcnt_reg  <= 8'd0;
               end else if (taken && !lu && BR_PENALTY > 1) begin
                  state_reg <= ST_FLUSH;
                  fcnt_reg  <= 3'd1;
               end
            end
            ST_FLUSH: begin
               if (memhold) begin
                  state_reg <= ST_MEMWAIT;
                  tcnt_reg  <= 8'd0;
               end else if (fcnt_reg == 3'(BR_PENALTY - 1)) begin
                  state_reg <= ST_RUN;
               end else begin
                  fcnt_reg <= fcnt_reg + 3'd1;
               end
            end
            ST_MEMWAIT: begin
               if (mem_ready) begin
                  state_reg <= ST_RUN;
               end else if (tcnt_reg == 8'(MEM_TIMEOUT - 1)) begin
                  state_reg   <= ST_RUN;
                  mem_timeout <= 1'b1;
               end else begin
                  tcnt_reg <= tcnt_reg + 8'd1;
               end
            end
            default: state_reg <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two differently parameterised instances share
// one stimulus stream and are checked against a remaining-cycles reference model.
module tb_pipeline_hazard_ctrl;

   localparam int PEN_A = 3, TMO_A = 15;
   localparam int PEN_B = 1, TMO_B = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       clrn;
   logic [4:0] id_rs, id_rt, exe_rn, mem_rn;
   logic       id_use_rs, id_use_rt, exe_wreg, exe_m2reg;
   logic       mem_wreg, mem_m2reg, mem_wmem, mem_ready;
   logic [1:0] id_pcsource;

   logic [1:0]  fwda_o [2];
   logic [1:0]  fwdb_o [2];
   logic [1:0]  state_o [2];
   logic        wpc_o [2], wir_o [2], bub_o [2], frz_o [2], fl_o [2], to_o [2];
   logic [15:0] stall_a, flush_a;
   logic [3:0]  stall_b, flush_b;

   pipeline_hazard_ctrl #(.BR_PENALTY(PEN_A), .MEM_TIMEOUT(TMO_A), .CNT_W(16)) dut_a (
      .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
      .id_use_rt(id_use_rt), .id_pcsource(id_pcsource), .exe_wreg(exe_wreg),
      .exe_m2reg(exe_m2reg), .exe_rn(exe_rn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
      .mem_wmem(mem_wmem), .mem_rn(mem_rn), .mem_ready(mem_ready),
      .fwda(fwda_o[0]), .fwdb(fwdb_o[0]), .wpc(wpc_o[0]), .wir(wir_o[0]),
      .bubble_ex(bub_o[0]), .freeze(frz_o[0]), .flush_if(fl_o[0]),
      .mem_timeout(to_o[0]), .state(state_o[0]), .stall_cnt(stall_a), .flush_cnt(flush_a)
   );

   pipeline_hazard_ctrl #(.BR_PENALTY(PEN_B), .MEM_TIMEOUT(TMO_B), .CNT_W(4)) dut_b (
      .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
      .id_use_rt(id_use_rt), .id_pcsource(id_pcsource), .exe_wreg(exe_wreg),
      .exe_m2reg(exe_m2reg), .exe_rn(exe_rn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
      .mem_wmem(mem_wmem), .mem_rn(mem_rn), .mem_ready(mem_ready),
      .fwda(fwda_o[1]), .fwdb(fwdb_o[1]), .wpc(wpc_o[1]), .wir(wir_o[1]),
      .bubble_ex(bub_o[1]), .freeze(frz_o[1]), .flush_if(fl_o[1]),
      .mem_timeout(to_o[1]), .state(state_o[1]), .stall_cnt(stall_b), .flush_cnt(flush_b)
   );

   int compared = 0, mismatched = 0;

   // Reference model: cycles of kill still owed, whether a memory wait is open,
   // how many wait cycles have elapsed, and the pending timeout pulse.
   int kill_left [2], waited [2], in_wait [2], pulse [2], stalls [2], kills [2];
   int pen [2], tmo [2], cmax [2];
   int exp_wpc [2], exp_fi [2];

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
      end
   endtask

   function automatic int fwd_of(input logic [4:0] r);
      if (exe_wreg && !exe_m2reg && exe_rn != 0 && exe_rn == r) return 1;
      if (mem_wreg && mem_rn != 0 && mem_rn == r) return mem_m2reg ? 3 : 2;
      return 0;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         kill_left[d] = 0; waited[d] = 0; in_wait[d] = 0;
         pulse[d] = 0; stalls[d] = 0; kills[d] = 0;
      end
   endtask

   task automatic idle();
      clrn = 1'b1; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_pcsource = 0;
      exe_wreg = 0; exe_m2reg = 0; exe_rn = 0; mem_wreg = 0; mem_m2reg = 0;
      mem_wmem = 0; mem_rn = 0; mem_ready = 1'b1;
   endtask

   // One clock: check everything mid-cycle against the model, then advance both.
   task automatic step();
      bit lu, mh, taken, hold;
      int e_fa, e_fb, e_wpc, e_bub, e_frz, e_fi, e_st;
      @(negedge clk);
      lu = exe_wreg && exe_m2reg && exe_rn != 0 &&
           ((id_use_rs && id_rs == exe_rn) || (id_use_rt && id_rt == exe_rn));
      mh = (mem_m2reg || mem_wmem) && !mem_ready;
      taken = id_pcsource != 0;
      for (int d = 0; d < 2; d++) begin
         hold = mh || (in_wait[d] != 0 && !mem_ready);
         e_fa = 0; e_fb = 0; e_wpc = 1; e_bub = 0; e_frz = 0; e_fi = 0;
         if (clrn) begin
            e_fa = fwd_of(id_rs);
            e_fb = fwd_of(id_rt);
            if (hold) begin e_wpc = 0; e_frz = 1; end
            else if (lu) begin e_wpc = 0; e_bub = 1; end
            else if (kill_left[d] > 0 || taken) e_fi = 1;
         end
         e_st = in_wait[d] != 0 ? 2 : (kill_left[d] > 0 ? 1 : 0);
         chk("fwda", d, 32'(fwda_o[d]), e_fa);
         chk("fwdb", d, 32'(fwdb_o[d]), e_fb);
         chk("wpc", d, 32'(wpc_o[d]), e_wpc);
         chk("wir", d, 32'(wir_o[d]), e_wpc);
         chk("bubble_ex", d, 32'(bub_o[d]), e_bub);
         chk("freeze", d, 32'(frz_o[d]), e_frz);
         chk("flush_if", d, 32'(fl_o[d]), e_fi);
         chk("state", d, 32'(state_o[d]), e_st);
         chk("mem_timeout", d, 32'(to_o[d]), pulse[d]);
         chk("stall_cnt", d, d == 0 ? 32'(stall_a) : 32'(stall_b), stalls[d]);
         chk("flush_cnt", d, d == 0 ? 32'(flush_a) : 32'(flush_b), kills[d]);
         exp_wpc[d] = e_wpc;
         exp_fi[d]  = e_fi;
      end
      @(posedge clk);
      if (!clrn) model_reset();
      else begin
         for (int d = 0; d < 2; d++) begin
            if (exp_wpc[d] == 0 && stalls[d] < cmax[d]) stalls[d]++;
            if (exp_fi[d] == 1 && kills[d] < cmax[d]) kills[d]++;
            pulse[d] = 0;
            if (in_wait[d] != 0) begin
               waited[d]++;
               if (mem_ready) in_wait[d] = 0;
               else if (waited[d] == tmo[d]) begin in_wait[d] = 0; pulse[d] = 1; end
            end else if (mh) begin
               in_wait[d] = 1; waited[d] = 0; kill_left[d] = 0;
            end else if (kill_left[d] > 0) kill_left[d]--;
            else if (taken && !lu) kill_left[d] = pen[d] - 1;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      clrn = 1'b0;
      step();
      clrn = 1'b1;
   endtask

   initial begin
      pen[0] = PEN_A; tmo[0] = TMO_A; cmax[0] = 65535;
      pen[1] = PEN_B; tmo[1] = TMO_B; cmax[1] = 15;
      idle();
      clrn = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      do_reset();

      // Forwarding priority and r0
      exe_wreg = 1; exe_rn = 5; id_rs = 5;
      step();
      chk("fwda_exe", 0, 32'(fwda_o[0]), 1);
      mem_wreg = 1; mem_rn = 5;
      step();
      chk("fwda_exe_wins", 0, 32'(fwda_o[0]), 1);
      exe_rn = 0; mem_rn = 0; id_rs = 0;
      step();
      chk("fwda_r0", 0, 32'(fwda_o[0]), 0);

      // Load-use bubble, then forwarding from the load in MEM
      idle();
      exe_wreg = 1; exe_m2reg = 1; exe_rn = 3; id_rt = 3; id_use_rt = 1;
      step();
      exe_wreg = 0; exe_m2reg = 0; exe_rn = 0;
      mem_wreg = 1; mem_m2reg = 1; mem_rn = 3;
      step();
      chk("fwdb_mem_mo", 0, 32'(fwdb_o[0]), 3);

      // Taken branch kill window
      idle();
      do_reset();
      id_pcsource = 2'b01;
      step();
      id_pcsource = 2'b00;
      repeat (3) step();
      chk("flush_cnt_branch", 0, 32'(flush_a), 3);
      chk("flush_cnt_branch", 1, 32'(flush_b), 1);

      // Four-cycle memory stall without timeout
      do_reset();
      mem_m2reg = 1; mem_ready = 0;
      repeat (4) step();
      mem_ready = 1;
      step();
      chk("stall_cnt_mem", 0, 32'(stall_a), 4);

      // Memory never ready: timeouts and counter saturation
      idle();
      do_reset();
      mem_m2reg = 1; mem_ready = 0;
      repeat (20) step();
      chk("stall_cnt_20", 0, 32'(stall_a), 20);
      chk("stall_cnt_sat", 1, 32'(stall_b), 15);

      // Reset while waiting on memory
      clrn = 1'b0;
      step();
      chk("state_after_reset", 0, 32'(state_o[0]), 0);
      chk("stall_after_reset", 0, 32'(stall_a), 0);
      chk("timeout_after_reset", 0, 32'(to_o[0]), 0);

      // Randomised traffic on a small register window to provoke hazards
      idle();
      for (int i = 0; i < 600; i++) begin
         clrn        = ($urandom_range(0, 63) != 0);
         id_rs       = 5'($urandom_range(0, 3));
         id_rt       = 5'($urandom_range(0, 3));
         id_use_rs   = 1'($urandom);
         id_use_rt   = 1'($urandom);
         id_pcsource = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         exe_wreg    = 1'($urandom);
         exe_m2reg   = 1'($urandom);
         exe_rn      = 5'($urandom_range(0, 3));
         mem_wreg    = 1'($urandom);
         mem_m2reg   = ($urandom_range(0, 3) == 0);
         mem_wmem    = ($urandom_range(0, 3) == 0);
         mem_rn      = 5'($urandom_range(0, 3));
         mem_ready   = ($urandom_range(0, 9) < 6);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
